bnn_seq_classifier: RTL and testbench

Parametrised, sequential binary-neural-network classifier. Holds a writable bank of `N_CLASS` binary weight vectors and scores one captured `N_IN`-bit input sample against them, one class per cycle, using XNOR-popcount. It returns the arg-max class and its score through a valid/ready output. It sits between the input-pin sampler and the output-pin driver, and is the generalised, loadable successor to the fixed-weight first-match classifier.

---
 rtl/bnn_pkg.sv | 19 +
 rtl/bnn_popcount.sv | 18 +
 rtl/bnn_seq_classifier.sv | 132 +++++++++++++
 tb/tb_bnn_seq_classifier.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and elaboration helpers for the sequential BNN classifier.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_DONE
  } bnn_state_e;

  // All-ones class code reserved for "no class cleared the threshold".
  function automatic int unsigned reject_code(input int unsigned out_w);
    return (32'd1 << out_w) - 32'd1;
  endfunction

  function automatic bit params_ok(input int n_in, input int n_class, input int out_w);
    return (n_in >= 1) && (n_class >= 2) && (n_class <= ((1 << out_w) - 1));
  endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational population count of an N_IN-bit vector.
module bnn_popcount #(
  parameter int N_IN  = 7,
  parameter int CNT_W = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0]  vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  // NOTE: always_comb assigns a default before accumulating, so no latch is inferred.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt_o = cnt_o + CNT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/bnn_seq_classifier.sv
// Loadable XNOR-popcount classifier scoring one class per cycle and reporting the arg-max.
// Optional BNN_THRESH_EN adds a thresh port; best scores below it report the reject code.
module bnn_seq_classifier
  import bnn_pkg::*;
#(
  parameter int N_IN    = 7,
  parameter int N_CLASS = 10,
  parameter int OUT_W   = 4,
  parameter int SCORE_W = $clog2(N_IN + 1),
  parameter int ADDR_W  = $clog2(N_CLASS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_data,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [N_IN-1:0]    wr_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_class,
  output logic [SCORE_W-1:0] out_score,
  output logic               busy
`ifdef BNN_THRESH_EN
  ,
  input  logic [SCORE_W-1:0] thresh
`endif
);

  if (!params_ok(N_IN, N_CLASS, OUT_W)) begin : g_param_err
    $error("bnn_seq_classifier: illegal N_IN/N_CLASS/OUT_W combination");
  end

  bnn_state_e          state_q, state_d;
  logic [N_IN-1:0]     w_q [N_CLASS];
  logic [N_IN-1:0]     x_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [SCORE_W-1:0]  best_q;
  logic [ADDR_W-1:0]   best_idx_q;
  logic [OUT_W-1:0]    out_class_q, out_class_d;
  logic [SCORE_W-1:0]  out_score_q;

  logic [SCORE_W-1:0]  score;
  logic                take;
  logic                last;
  logic [SCORE_W-1:0]  win_score;
  logic [ADDR_W-1:0]   win_idx;

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_class = out_class_q;
  assign out_score = out_score_q;

  bnn_popcount #(
    .N_IN  (N_IN),
    .CNT_W (SCORE_W)
  ) u_popcount (
    .vec_i (~(x_q ^ w_q[idx_q])),
    .cnt_o (score)
  );

  // Strict greater-than keeps the lowest index on ties.
  assign take      = (idx_q == '0) || (score > best_q);
  assign win_score = take ? score : best_q;
  assign win_idx   = take ? idx_q : best_idx_q;
  assign last      = (idx_q == ADDR_W'(N_CLASS - 1));

`ifdef BNN_THRESH_EN
  localparam logic [OUT_W-1:0] REJECT = OUT_W'(reject_code(OUT_W));
  assign out_class_d = (win_score < thresh) ? REJECT : OUT_W'(win_idx);
`else
  assign out_class_d = OUT_W'(win_idx);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EVAL;
      ST_EVAL: if (last)     state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the weight bank must read as zero after reset, so it is built from resettable flops, not RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CLASS; k++) w_q[k] <= '0;
    end else if (wr_en && !busy && (32'(wr_addr) < N_CLASS)) begin
      w_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      out_class_q <= '0;
      out_score_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q   <= in_data;
            idx_q <= '0;
          end
        end
        ST_EVAL: begin
          best_q     <= win_score;
          best_idx_q <= win_idx;
          if (last) begin
            out_class_q <= out_class_d;
            out_score_q <= win_score;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Directed self-checking bench for bnn_seq_classifier (default N_IN=7, N_CLASS=10, OUT_W=4).
module tb_bnn_seq_classifier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_data = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [6:0] wr_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_class;
  logic [2:0] out_score;
  logic       busy;
  logic [2:0] thresh = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bnn_seq_classifier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .busy      (busy)
`ifdef BNN_THRESH_EN
    ,
    .thresh    (thresh)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [3:0] addr, input logic [6:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // Accepts x, optionally keeps a write strobe up through EVAL, waits for out_valid, checks, then handshakes.
  task automatic run(input string tag, input logic [6:0] x, input logic ev_wr, input logic [3:0] ev_addr,
                     input logic [6:0] ev_data, input logic [3:0] exp_class, input logic [2:0] exp_score);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    wr_en    = ev_wr;
    wr_addr  = ev_addr;
    wr_data  = ev_data;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (out_valid) begin
        lat = n;
        break;
      end
      tick();
    end
    wr_en = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd11);
    check({tag, "_class"}, 32'(out_class), 32'(exp_class));
    check({tag, "_score"}, 32'(out_score), 32'(exp_score));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // 1: reset then idle
    tick();
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_out_score", 32'(out_score), 32'd0);

    // 2: single matching weight at row 3; other rows score the 3 zeros of x
    write_w(4'd3, 7'b1010101);
    in_valid = 1'b1;
    in_data  = 7'b1010101;
    tick();
    in_valid = 1'b0;
    begin
      int lat = 0;
      for (int n = 1; n <= 40; n++) begin
        if (out_valid) begin
          lat = n;
          break;
        end
        check("t2_in_ready_low", 32'(in_ready), 32'd0);
        tick();
      end
      check("t2_latency", 32'(lat), 32'd11);
    end
    check("t2_class", 32'(out_class), 32'd3);
    check("t2_score", 32'(out_score), 32'd7);

    // 4: stall in DONE for 5 cycles
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_class", 32'(out_class), 32'd3);
      check("t4_hold_score", 32'(out_score), 32'd7);
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_idle_in_ready", 32'(in_ready), 32'd1);
    check("t4_idle_valid", 32'(out_valid), 32'd0);

    // 3: all weights zero, x=0 -> every score 7, tie resolves to class 0
    write_w(4'd3, 7'b0000000);
    run("t3_tie_all", 7'h00, 1'b0, 4'd0, 7'h00, 4'd0, 3'd7);

    // Tie between rows 2 and 7 at score 7 (others 5) -> lowest index wins
    write_w(4'd2, 7'b0000011);
    write_w(4'd7, 7'b0000011);
    run("tie_2_7", 7'b0000011, 1'b0, 4'd0, 7'h00, 4'd2, 3'd7);
    write_w(4'd2, 7'b0000000);
    write_w(4'd7, 7'b0000000);

    // Write and accept in the same cycle: new weight is visible to the sample
    wr_en   = 1'b1;
    wr_addr = 4'd4;
    wr_data = 7'b0110011;
    run("wr_and_accept", 7'b0110011, 1'b0, 4'd0, 7'h00, 4'd4, 3'd7);
    write_w(4'd4, 7'b0000000);

    // Write during EVAL is dropped: x=7F on zero weights scores 0 everywhere, twice
    run("busy_wr_a", 7'h7F, 1'b1, 4'd5, 7'h7F, 4'd0, 3'd0);
    run("busy_wr_b", 7'h7F, 1'b0, 4'd0, 7'h00, 4'd0, 3'd0);

    // Last class index wins
    write_w(4'd9, 7'h7F);
    run("last_idx", 7'h7F, 1'b0, 4'd0, 7'h00, 4'd9, 3'd7);

    // Out-of-range row addresses are ignored
    write_w(4'd10, 7'h7F);
    write_w(4'd15, 7'h7F);
    run("oob_addr", 7'h7F, 1'b0, 4'd0, 7'h00, 4'd9, 3'd7);

    // 5: write during EVAL, reset at the 4th EVAL cycle
    in_valid = 1'b1;
    in_data  = 7'h00;
    tick();
    in_valid = 1'b0;
    wr_en    = 1'b1;
    wr_addr  = 4'd5;
    wr_data  = 7'h7F;
    tick();
    tick();
    tick();
    check("t5_busy_pre_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    wr_en = 1'b0;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_class", 32'(out_class), 32'd0);
    check("t5_out_score", 32'(out_score), 32'd0);
    run("t5_fresh_00", 7'h00, 1'b0, 4'd0, 7'h00, 4'd0, 3'd7);
    // Would be class 9 or 5 if the bank survived reset or took the busy write
    run("t5_fresh_7f", 7'h7F, 1'b0, 4'd0, 7'h00, 4'd0, 3'd0);

    // 6: threshold reject
    thresh = 3'd7;
`ifdef BNN_THRESH_EN
    run("t6_reject", 7'h7F, 1'b0, 4'd0, 7'h00, 4'hF, 3'd0);
    run("t6_at_thresh", 7'h00, 1'b0, 4'd0, 7'h00, 4'd0, 3'd7);
`else
    run("t6_no_thresh", 7'h7F, 1'b0, 4'd0, 7'h00, 4'd0, 3'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
